// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// Imported by the LSU top, its load extender and the memory interface users.
package lsu_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      RD_WAIT,
      RESP
   } lsu_state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [2:0] SZ_B = 3'b000;
   localparam logic [2:0] SZ_H = 3'b001;
   localparam logic [2:0] SZ_W = 3'b010;

   // Access size code as understood by the data memory
   function automatic logic [2:0] size_of(logic [2:0] f3);
      return {1'b0, f3[1:0]};
   endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory bus between the LSU (master) and data_memory (slave).
// Read data appears one cycle after the address is presented.
interface memory_if #(
   parameter int AW = 11
) ();

   logic [AW-1:0] addr;
   logic          wr;
   logic [2:0]    writeEnable;
   logic [31:0]   wdata;
   logic [31:0]   rdata;

   modport master (
      output addr,
      output wr,
      output writeEnable,
      output wdata,
      input  rdata
   );

   modport slave (
      input  addr,
      input  wr,
      input  writeEnable,
      input  wdata,
      output rdata
   );

endinterface

// File: rtl/load_store_unit_load_extend.sv
// Masks and extends right-aligned load data from memory
// according to the load funct3.
module load_extend
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic [31:0] rdata_i,
   output logic [31:0] data_o
);

   // Select extension rule from funct3
   always_comb begin
      data_o = rdata_i;
      case (funct3_i)
         F3_B:    data_o = {{24{rdata_i[7]}}, rdata_i[7:0]};
         F3_BU:   data_o = {24'h0, rdata_i[7:0]};
         F3_H:    data_o = {{16{rdata_i[15]}}, rdata_i[15:0]};
         F3_HU:   data_o = {16'h0, rdata_i[15:0]};
         default: data_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one CPU request at a time to data memory,
// with alignment/range checks and load data extension.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int AW = 11,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_we,
   input  logic [2:0]    req_funct3,
   input  logic [DW-1:0] req_addr,
   input  logic [DW-1:0] req_wdata,
   output logic          rsp_valid,
   output logic [DW-1:0] rsp_rdata,
   output logic          rsp_misaligned,
   output logic          rsp_fault,
   memory_if.master      mem_if
);

   lsu_state_t    state_q, state_d;
   logic          we_q;
   logic [2:0]    f3_q;
   logic          mis_q, flt_q;
   logic [DW-1:0] rdata_q;
   logic [AW-1:0] addr_q;
   logic [2:0]    sz_q;
   logic [DW-1:0] wdata_q;
   logic [DW-1:0] ext_w;

   logic accept;
   logic mis_c;
   logic flt_c;

   assign accept = req_valid && (state_q == IDLE);

   // Alignment and range/encoding checks on the incoming request
   always_comb begin
      mis_c = 1'b0;
      flt_c = 1'b0;
      if (req_funct3[1:0] == 2'b01)
         mis_c = req_addr[0];
      else if (req_funct3[1:0] == 2'b10)
         mis_c = |req_addr[1:0];
      if (|req_addr[DW-1:AW])
         flt_c = 1'b1;
      if (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11)
         flt_c = 1'b1;
      if (req_we && req_funct3[2])
         flt_c = 1'b1;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:
            if (accept)
               state_d = (mis_c || flt_c) ? RESP : ISSUE;
         ISSUE:
            state_d = we_q ? RESP : RD_WAIT;
         RD_WAIT:
            state_d = RESP;
         RESP:
            state_d = IDLE;
         default:
            state_d = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   // Request capture, memory bus registers and load data capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q    <= 1'b0;
         f3_q    <= 3'b000;
         mis_q   <= 1'b0;
         flt_q   <= 1'b0;
         rdata_q <= '0;
         addr_q  <= '0;
         sz_q    <= SZ_W;
         wdata_q <= '0;
      end else if (accept) begin
         we_q    <= req_we;
         f3_q    <= req_funct3;
         mis_q   <= mis_c;
         flt_q   <= flt_c;
         rdata_q <= '0;
         if (!mis_c && !flt_c) begin
            addr_q  <= req_addr[AW-1:0];
            sz_q    <= size_of(req_funct3);
            wdata_q <= req_wdata;
         end
      end else if (state_q == RD_WAIT) begin
         rdata_q <= ext_w;
      end
   end

   load_extend u_ext (
      .funct3_i (f3_q),
      .rdata_i  (mem_if.rdata),
      .data_o   (ext_w)
   );

   assign req_ready          = (state_q == IDLE);
   assign rsp_valid          = (state_q == RESP);
   assign rsp_rdata          = rdata_q;
   assign rsp_misaligned     = mis_q;
   assign rsp_fault          = flt_q;
   assign mem_if.addr        = addr_q;
   assign mem_if.writeEnable = sz_q;
   assign mem_if.wdata       = wdata_q;
   assign mem_if.wr          = (state_q == ISSUE) && we_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: vector table plus scoreboard,
// with a byte-addressed memory model behind memory_if.
module tb_load_store_unit;

   localparam int AW = 11;

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        mis;
      logic        flt;
      int          lat;
   } vec_t;

   typedef struct {
      logic [31:0] rdata;
      logic        mis;
      logic        flt;
      int          acc;
      int          lat;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'b000;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_misaligned;
   logic        rsp_fault;

   int cyc = 0;
   int errs = 0;
   int checks = 0;
   int wr_cnt = 0;
   exp_t sb[$];
   vec_t vt[16];

   logic [7:0] mem [0:2047];

   memory_if #(.AW(AW)) mif ();

   load_store_unit #(.AW(AW), .DW(32)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_we         (req_we),
      .req_funct3     (req_funct3),
      .req_addr       (req_addr),
      .req_wdata      (req_wdata),
      .rsp_valid      (rsp_valid),
      .rsp_rdata      (rsp_rdata),
      .rsp_misaligned (rsp_misaligned),
      .rsp_fault      (rsp_fault),
      .mem_if         (mif.master)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Memory model: little-endian, 1-cycle read latency, right-aligned reads
   always @(posedge clk) begin
      if (mif.wr) begin
         case (mif.writeEnable)
            3'b000: mem[mif.addr] <= mif.wdata[7:0];
            3'b001: begin
               mem[mif.addr]      <= mif.wdata[7:0];
               mem[mif.addr + 1]  <= mif.wdata[15:8];
            end
            default: begin
               mem[mif.addr]      <= mif.wdata[7:0];
               mem[mif.addr + 1]  <= mif.wdata[15:8];
               mem[mif.addr + 2]  <= mif.wdata[23:16];
               mem[mif.addr + 3]  <= mif.wdata[31:24];
            end
         endcase
      end
      case (mif.writeEnable)
         3'b000: mif.rdata <= {24'h0, mem[mif.addr]};
         3'b001: mif.rdata <= {16'h0, mem[mif.addr + 1], mem[mif.addr]};
         default: mif.rdata <= {mem[mif.addr + 3], mem[mif.addr + 2],
                                mem[mif.addr + 1], mem[mif.addr]};
      endcase
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errs++;
         $display("FAIL %s: got %h expected %h", nm, act, req);
      end
   endtask

   task automatic do_req(input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input exp_t e);
      int n;
      exp_t x;
      @(negedge clk);
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wd;
      req_valid  = 1'b1;
      n = 0;
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         checks++;
         errs++;
         $display("FAIL accept_timeout: got ready=0 expected ready=1");
         req_valid = 1'b0;
         return;
      end
      x = e;
      x.acc = cyc;
      sb.push_back(x);
      @(posedge clk);
      #1 req_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (sb.size() != 0) begin
         errs++;
         $display("FAIL rsp_timeout: got %0d pending expected 0", sb.size());
         sb.delete();
      end
   endtask

   function automatic exp_t mk(input logic [31:0] rd, input logic m,
                               input logic f, input int l);
      exp_t e;
      e.rdata = rd;
      e.mis   = m;
      e.flt   = f;
      e.acc   = 0;
      e.lat   = l;
      return e;
   endfunction

   initial begin
      vt[0]  = '{1, 3'b010, 32'h10,  32'hDEADBEEF, 32'h0,        0, 0, 2};
      vt[1]  = '{0, 3'b010, 32'h10,  32'h0,        32'hDEADBEEF, 0, 0, 3};
      vt[2]  = '{1, 3'b000, 32'h13,  32'h80,       32'h0,        0, 0, 2};
      vt[3]  = '{0, 3'b000, 32'h13,  32'h0,        32'hFFFFFF80, 0, 0, 3};
      vt[4]  = '{0, 3'b100, 32'h13,  32'h0,        32'h00000080, 0, 0, 3};
      vt[5]  = '{1, 3'b001, 32'h22,  32'h8001,     32'h0,        0, 0, 2};
      vt[6]  = '{0, 3'b001, 32'h22,  32'h0,        32'hFFFF8001, 0, 0, 3};
      vt[7]  = '{0, 3'b101, 32'h22,  32'h0,        32'h00008001, 0, 0, 3};
      vt[8]  = '{0, 3'b010, 32'h06,  32'h0,        32'h0,        1, 0, 1};
      vt[9]  = '{1, 3'b010, 32'h800, 32'h11111111, 32'h0,        0, 1, 1};
      vt[10] = '{1, 3'b000, 32'h7FF, 32'h5A,       32'h0,        0, 0, 2};
      vt[11] = '{0, 3'b100, 32'h7FF, 32'h0,        32'h0000005A, 0, 0, 3};
      vt[12] = '{0, 3'b010, 32'h10,  32'h0,        32'h80ADBEEF, 0, 0, 3};
      vt[13] = '{0, 3'b001, 32'h801, 32'h0,        32'h0,        1, 1, 1};
      vt[14] = '{0, 3'b011, 32'h0,   32'h0,        32'h0,        0, 1, 1};
      vt[15] = '{1, 3'b100, 32'h30,  32'h22,       32'h0,        0, 1, 1};
   end

   initial begin
      fork
         begin : main
            int acc_n;
            int wr0;
            repeat (2) @(negedge clk);
            chk("rst_ready", {31'h0, req_ready}, 32'h1);
            chk("rst_wr", {31'h0, mif.wr}, 32'h0);
            rst_n = 1'b1;
            #1;
            chk("rst_ready_out", {31'h0, req_ready}, 32'h1);
            chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
            chk("rst_mis", {31'h0, rsp_misaligned}, 32'h0);
            chk("rst_fault", {31'h0, rsp_fault}, 32'h0);
            chk("rst_rdata", rsp_rdata, 32'h0);
            chk("rst_addr", {21'h0, mif.addr}, 32'h0);
            chk("rst_wdata", mif.wdata, 32'h0);
            chk("rst_we_code", {29'h0, mif.writeEnable}, 32'h2);

            for (int i = 0; i < 16; i++) begin
               do_req(vt[i].we, vt[i].f3, vt[i].addr, vt[i].wdata,
                      mk(vt[i].rdata, vt[i].mis, vt[i].flt, vt[i].lat));
               drain();
            end
            chk("store_wr_pulses", wr_cnt, 32'd4);

            // Request held valid through RESP is taken once per IDLE
            wr0 = wr_cnt;
            acc_n = 0;
            @(negedge clk);
            req_we     = 1'b0;
            req_funct3 = 3'b001;
            req_addr   = 32'h1;
            req_valid  = 1'b1;
            for (int i = 0; i < 6; i++) begin
               if (req_ready) begin
                  exp_t e;
                  e = mk(32'h0, 1'b1, 1'b0, 1);
                  e.acc = cyc;
                  sb.push_back(e);
                  acc_n++;
               end
               @(negedge clk);
            end
            req_valid = 1'b0;
            drain();
            chk("held_accepts", acc_n, 32'd3);
            chk("held_no_wr", wr_cnt, wr0);

            // Reset while waiting for read data
            do_req(1'b1, 3'b010, 32'h40, 32'h12345678,
                   mk(32'h0, 0, 0, 2));
            drain();
            do_req(1'b0, 3'b010, 32'h40, 32'h0,
                   mk(32'h12345678, 0, 0, 3));
            @(negedge clk);
            @(negedge clk);
            chk("rdwait_busy", {31'h0, req_ready}, 32'h0);
            rst_n = 1'b0;
            #1;
            chk("midrst_ready", {31'h0, req_ready}, 32'h1);
            chk("midrst_wr", {31'h0, mif.wr}, 32'h0);
            void'(sb.pop_back());
            @(negedge clk);
            rst_n = 1'b1;
            repeat (4) @(negedge clk);
            do_req(1'b0, 3'b010, 32'h40, 32'h0,
                   mk(32'h12345678, 0, 0, 3));
            drain();
         end
         begin : mon
            forever begin
               @(negedge clk);
               if (mif.wr) wr_cnt++;
               if (rsp_valid) begin
                  if (sb.size() == 0) begin
                     checks++;
                     errs++;
                     $display("FAIL unexpected_rsp: got rsp_valid=1 expected 0");
                  end else begin
                     exp_t e;
                     e = sb.pop_front();
                     chk("rsp_rdata", rsp_rdata, e.rdata);
                     chk("rsp_mis", {31'h0, rsp_misaligned}, {31'h0, e.mis});
                     chk("rsp_fault", {31'h0, rsp_fault}, {31'h0, e.flt});
                     chk("rsp_latency", cyc - e.acc, e.lat);
                  end
               end
            end
         end
      join_any
      disable fork;
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
